trans_update_scheduler: RTL

- Sequences the per-transducer duty/phase reload from a shared drive-data BRAM into the PWM-side register bank.
- On each trigger it sweeps transducer indices 0..DEPTH-1, issues one BRAM read per clock and forwards the returned duty/phase with its index to the register bank.
- Triggers come from an explicit START pulse or from an internal period counter.
- Sits between the CPU-written BRAM and the modulator/silencer/PWM chain, in the CLK_L domain.

---
 rtl/trans_update_scheduler.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/trans_update_scheduler.sv
// trans_update_scheduler
// Reloads per-transducer duty/phase from the drive-data BRAM into the PWM
// register bank. A trigger (START pulse or internal period tick) sweeps
// indices 0..DEPTH-1, one BRAM read per clock. Each read result is forwarded
// with its index once the read latency has elapsed.
//
// Optional feature macro: TRANS_SCHED_RESTART_EN. When it is defined, a
// trigger that arrives mid-sweep restarts the sweep at index 0.
//
// Ports:
//   CLK, RESET_N        clock and asynchronous active-low reset
//   START               one-clock update request
//   PERIOD[15:0]        auto-trigger period in clocks (0 = off)
//   OVERRUN_CLR         clears OVERRUN (a simultaneous new overrun wins)
//   BRAM_EN, BRAM_ADDR  registered read request
//   BRAM_DOUT           read data {phase, duty}
//   OUT_VALID, OUT_IDX  index of the forwarded value
//   DUTY_OUT, PHASE_OUT forwarded values; they hold while OUT_VALID is 0
//   BUSY, DONE          sweep in progress / end-of-sweep pulse
//   OVERRUN             sticky flag for a trigger that arrived mid-sweep
module trans_update_scheduler #(
    parameter int unsigned WIDTH      = 13,
    parameter int unsigned DEPTH      = 249,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned ADDR_W     = 8
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 START,
    input  logic [15:0]          PERIOD,
    input  logic                 OVERRUN_CLR,
    output logic                 BRAM_EN,
    output logic [ADDR_W-1:0]    BRAM_ADDR,
    input  logic [2*WIDTH-1:0]   BRAM_DOUT,
    output logic                 OUT_VALID,
    output logic [ADDR_W-1:0]    OUT_IDX,
    output logic [WIDTH-1:0]     DUTY_OUT,
    output logic [WIDTH-1:0]     PHASE_OUT,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 OVERRUN
);

    localparam int unsigned PER_W = 16;
    localparam int unsigned DRN_W = 3;
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(DEPTH - 1);
    localparam logic [DRN_W-1:0]  LAST_DRAIN = DRN_W'(RD_LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FIN} state_t;

    state_t                r_state, w_state_n;
    logic                  r_en, w_en_n;
    logic [ADDR_W-1:0]     r_addr, w_addr_n;
    logic [DRN_W-1:0]      r_drain, w_drain_n;
    logic                  r_busy, r_done, r_ovr;
    logic                  w_trig, w_tick, w_ovr_evt, w_restart;
    logic [PER_W-1:0]      r_per_cnt, r_period_q;
    logic [RD_LATENCY-1:0] r_vpipe;
    logic [ADDR_W-1:0]     r_ipipe [RD_LATENCY];
    logic [WIDTH-1:0]      r_duty_q, r_phase_q;

    // Period tick: suppressed in the cycle PERIOD changes, since the counter reloads then.
    assign w_tick = (PERIOD != '0) && (PERIOD == r_period_q) &&
                    (r_per_cnt == PERIOD - PER_W'(1));
    assign w_trig = START | w_tick;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_per_cnt  <= '0;
            r_period_q <= '0;
        end else begin
            r_period_q <= PERIOD;
            if ((PERIOD != r_period_q) || (PERIOD == '0) || w_tick)
                r_per_cnt <= '0;
            else
                r_per_cnt <= r_per_cnt + PER_W'(1);
        end
    end

    // Sweep FSM: next state plus next values of the registered request outputs.
    always_comb begin
        w_state_n = r_state;
        w_en_n    = 1'b0;
        w_addr_n  = r_addr;
        w_drain_n = r_drain;
        w_ovr_evt = 1'b0;
`ifdef TRANS_SCHED_RESTART_EN
        w_restart = w_trig;
`else
        w_restart = 1'b0;
`endif
        case (r_state)
            S_IDLE, S_FIN: begin
                if (w_trig) begin
                    w_state_n = S_ISSUE;
                    w_en_n    = 1'b1;
                    w_addr_n  = '0;
                end else begin
                    w_state_n = S_IDLE;
                end
            end
            S_ISSUE: begin
                w_ovr_evt = w_trig;
                if (w_restart) begin
                    w_en_n   = 1'b1;
                    w_addr_n = '0;
                end else if (r_addr == LAST_IDX) begin
                    w_state_n = S_DRAIN;
                    w_drain_n = '0;
                end else begin
                    w_en_n   = 1'b1;
                    w_addr_n = r_addr + ADDR_W'(1);
                end
            end
            S_DRAIN: begin
                w_ovr_evt = w_trig;
                if (w_restart) begin
                    w_state_n = S_ISSUE;
                    w_en_n    = 1'b1;
                    w_addr_n  = '0;
                end else if (r_drain == LAST_DRAIN) begin
                    w_state_n = S_FIN;
                end else begin
                    w_drain_n = r_drain + DRN_W'(1);
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
            r_en    <= 1'b0;
            r_addr  <= '0;
            r_drain <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_en    <= w_en_n;
            r_addr  <= w_addr_n;
            r_drain <= w_drain_n;
            r_busy  <= (w_state_n == S_ISSUE) || (w_state_n == S_DRAIN);
            r_done  <= (w_state_n == S_FIN);
            if (w_ovr_evt)
                r_ovr <= 1'b1;
            else if (OVERRUN_CLR)
                r_ovr <= 1'b0;
        end
    end

    // Return path: the index moves only with valid entries, so the last stage keeps the last index.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_vpipe <= '0;
            for (int j = 0; j < RD_LATENCY; j++) r_ipipe[j] <= '0;
            r_duty_q  <= '0;
            r_phase_q <= '0;
        end else begin
            r_vpipe[0] <= r_en;
            if (r_en) r_ipipe[0] <= r_addr;
            for (int j = 1; j < RD_LATENCY; j++) begin
                r_vpipe[j] <= r_vpipe[j-1];
                if (r_vpipe[j-1]) r_ipipe[j] <= r_ipipe[j-1];
            end
            if (OUT_VALID) begin
                r_duty_q  <= BRAM_DOUT[WIDTH-1:0];
                r_phase_q <= BRAM_DOUT[2*WIDTH-1:WIDTH];
            end
        end
    end

    // Data passes straight from BRAM_DOUT while valid, otherwise the last captured value is shown.
    assign DUTY_OUT  = OUT_VALID ? BRAM_DOUT[WIDTH-1:0]       : r_duty_q;
    assign PHASE_OUT = OUT_VALID ? BRAM_DOUT[2*WIDTH-1:WIDTH] : r_phase_q;
    assign OUT_VALID = r_vpipe[RD_LATENCY-1];
    assign OUT_IDX   = r_ipipe[RD_LATENCY-1];
    assign BRAM_EN   = r_en;
    assign BRAM_ADDR = r_addr;
    assign BUSY      = r_busy;
    assign DONE      = r_done;
    assign OVERRUN   = r_ovr;

endmodule
